motor_ctrl: RTL and testbench
=============================

# motor_ctrl

Multi-channel successor of the single-motor up/down controller. Drives `NCH` independent motors between an upper and a lower limit switch. Each channel adds the following to the plain up/down sequencing:
- rising-edge activation,
- stop-and-reverse on activate during motion,
- a per-channel travel timeout,
- a limit-conflict fault with explicit clear.

It sits between debounced panel/limit inputs and the motor driver stage; all outputs are registered.

## Interface
- `NCH`, 2, number of independent motor channels (≥1)
- `TO_W`, 16, width of per-channel travel timeout counter
- `TIMEOUT`, 1000, max cycles a motor output may stay asserted (2 ≤ TIMEOUT ≤ 2^TO_W−1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `activate`  in  NCH  per-channel request, level input, acted on rising edge only
- `up_limit`  in  NCH  per-channel upper limit switch, active-high
- `dn_limit`  in  NCH  per-channel lower limit switch, active-high
- `clr_fault`  in  NCH  per-channel fault clear, sampled as level
- `motor_up`  out  NCH  drive motor upward (registered)
- `motor_dn`  out  NCH  drive motor downward (registered)
- `fault`  out  NCH  channel in FAULT state (registered)

## Operation
- Channels are fully independent: one FSM, one timeout counter and one `act_q` register per channel, with no shared state.
- Edge detect: `rise = activate & ~act_q`. `act_q` is registered every cycle and resets to 0.
  - Consequence: `activate` held high through reset release yields one rise at the first edge.
- States (3-bit encoding): DECIDE, WAIT_DN, MOVE_DN, WAIT_UP, MOVE_UP, FAULT.
- DECIDE:
  - `up_limit` → WAIT_DN.
  - Otherwise → WAIT_UP.
  - Motor outputs held 0.
- WAIT_DN: on rise → MOVE_DN; set `motor_dn`=1; clear counter.
- WAIT_UP: on rise → MOVE_UP; set `motor_up`=1; clear counter.
- MOVE_UP, first matching condition wins:
  1. `up_limit` → `motor_up`=0, go to WAIT_DN.
  2. counter == TIMEOUT−1 → `motor_up`=0, `fault`=1, go to FAULT.
  3. rise → `motor_up`=0, go to WAIT_DN (stop; the next activation reverses).
  4. Otherwise counter+1.
- MOVE_DN: mirror of MOVE_UP with `dn_limit`/`motor_dn`, exiting to WAIT_UP.
- Conflict: `up_limit & dn_limit` in any non-FAULT state → FAULT. Both motors 0, `fault`=1. This overrides every other condition in the same cycle.
- FAULT:
  - Motors held 0; `activate` ignored, but `act_q` keeps tracking.
  - `clr_fault`=1 → `fault`=0, go to DECIDE, even if the limits are still conflicting. The conflict then re-faults on the following cycle.
- Invariant: `motor_up & motor_dn` is never 1 on the same channel.
- A direction change always passes through a WAIT state with both motors 0 for ≥1 cycle.
- `clr_fault` outside FAULT has no effect.
- Counter width is TO_W and never wraps: it is cleared on MOVE entry and saturates via the timeout exit.

## Timing
- Reset values: state DECIDE, `motor_up`=0, `motor_dn`=0, `fault`=0, `act_q`=0, counter 0, for every channel.
- Reset mid-motion drops the motor outputs asynchronously.
- Rise sampled at edge k in a WAIT state → motor output high from edge k (visible in cycle k+1).
- Limit sampled at edge k in a MOVE state → motor output low from edge k.
- Timeout: if no limit or rise occurs, the motor output is high for exactly TIMEOUT cycles, then `fault` rises on the same edge the motor falls.
- DECIDE always lasts 1 cycle. After reset, the earliest possible motor assertion is edge 2.
- Fault clear: `clr_fault` sampled at edge k → `fault` low from edge k, DECIDE in cycle k+1, WAIT in cycle k+2.

## Test plan
- **Up cycle:** ch0 both limits 0 after reset; pulse `activate` → `motor_up[0]`=1 next cycle. Assert `up_limit[0]` 20 cycles later → `motor_up[0]`=0 next cycle; state WAIT_DN; `motor_dn[0]` stays 0 until the next rise.
- **Stop/reverse:** during MOVE_DN, raise `activate` → `motor_dn`=0 next cycle. Hold `activate` high 10 cycles → no motion. Drop it and re-raise → `motor_up`=1.
- **Timeout:** TIMEOUT=8, no limits, one activation → `motor_up` high exactly 8 cycles, then `fault`=1. `activate` pulses are ignored. `clr_fault` → `fault`=0, and a motor asserts again on the next rise.
- **Conflict:** `up_limit`=`dn_limit`=1 while in MOVE_UP → motor 0 and `fault`=1 next cycle. `clr_fault` with the conflict still present → `fault` drops for exactly 1 cycle, then returns.
- **Independence:** NCH=2; ch0 times out while ch1 runs a full up/down cycle → ch1 outputs are unaffected. Simultaneous rises on both channels → both motors assert on the same edge.
- **Reset:** assert `rst_n`=0 mid-MOVE_DN asynchronously → all outputs 0 immediately. Release with `activate` held high → a rise is detected and motion starts at edge 2.

Source files
------------

// File: rtl/motor_ctrl.sv
// -----------------------------------------------------------------------------
// motor_ctrl
//
// Purpose: NCH independent up/down motor controllers. Each channel is driven
// between an upper and a lower limit switch. Motion starts on a rising edge of
// the channel's activate input. An activate edge during motion stops the motor,
// and the next edge moves it the other way. A per-channel travel timeout trips
// a fault, and so does a limit-switch conflict (both limits active at once). A
// fault is cleared explicitly with clr_fault. All outputs are registered.
//
// Parameters:
//   NCH      number of motor channels (>= 1)
//   TO_W     width of the per-channel travel counter
//   TIMEOUT  max cycles a motor output may stay high (2 .. 2**TO_W-1)
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   activate   in   NCH  per-channel request (level, acted on rising edge)
//   up_limit   in   NCH  per-channel upper limit switch, active-high
//   dn_limit   in   NCH  per-channel lower limit switch, active-high
//   clr_fault  in   NCH  per-channel fault clear (level)
//   motor_up   out  NCH  drive motor upward
//   motor_dn   out  NCH  drive motor downward
//   fault      out  NCH  channel is in FAULT state
// -----------------------------------------------------------------------------
module motor_ctrl #(
    parameter int NCH     = 2,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] activate,
    input  logic [NCH-1:0] up_limit,
    input  logic [NCH-1:0] dn_limit,
    input  logic [NCH-1:0] clr_fault,
    output logic [NCH-1:0] motor_up,
    output logic [NCH-1:0] motor_dn,
    output logic [NCH-1:0] fault
);

    typedef enum logic [2:0] {
        DECIDE  = 3'd0,
        WAIT_DN = 3'd1,
        MOVE_DN = 3'd2,
        WAIT_UP = 3'd3,
        MOVE_UP = 3'd4,
        FAULT   = 3'd5
    } state_t;

    // Counter value on the last permitted motor-on cycle.
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : ch_g
            state_t            state_q;
            logic [TO_W-1:0]   cnt_q;
            logic              act_q;
            logic              pend_q;
            logic              up_q;
            logic              dn_q;
            logic              flt_q;
            logic              rise;
            logic              conflict;
            logic              go;

            assign rise     = activate[gi] & ~act_q;
            assign conflict = up_limit[gi] & dn_limit[gi];
            // A rise seen while in DECIDE (e.g. activate held through reset
            // release) is carried into the following WAIT state. Without this,
            // it would be lost because DECIDE never starts motion itself.
            assign go       = rise | pend_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= DECIDE;
                    cnt_q   <= '0;
                    act_q   <= 1'b0;
                    pend_q  <= 1'b0;
                    up_q    <= 1'b0;
                    dn_q    <= 1'b0;
                    flt_q   <= 1'b0;
                end else begin
                    act_q  <= activate[gi];
                    pend_q <= 1'b0;
                    if (conflict && (state_q != FAULT)) begin
                        // A limit conflict beats every other condition.
                        state_q <= FAULT;
                        up_q    <= 1'b0;
                        dn_q    <= 1'b0;
                        flt_q   <= 1'b1;
                    end else begin
                        case (state_q)
                            DECIDE: begin
                                up_q    <= 1'b0;
                                dn_q    <= 1'b0;
                                pend_q  <= rise;
                                state_q <= up_limit[gi] ? WAIT_DN : WAIT_UP;
                            end
                            WAIT_DN: begin
                                if (go) begin
                                    state_q <= MOVE_DN;
                                    dn_q    <= 1'b1;
                                    cnt_q   <= '0;
                                end
                            end
                            WAIT_UP: begin
                                if (go) begin
                                    state_q <= MOVE_UP;
                                    up_q    <= 1'b1;
                                    cnt_q   <= '0;
                                end
                            end
                            MOVE_UP: begin
                                if (up_limit[gi]) begin
                                    up_q    <= 1'b0;
                                    state_q <= WAIT_DN;
                                end else if (cnt_q == CNT_LAST) begin
                                    up_q    <= 1'b0;
                                    flt_q   <= 1'b1;
                                    state_q <= FAULT;
                                end else if (rise) begin
                                    // Stop here; the next activation reverses.
                                    up_q    <= 1'b0;
                                    state_q <= WAIT_DN;
                                end else begin
                                    cnt_q <= cnt_q + TO_W'(1);
                                end
                            end
                            MOVE_DN: begin
                                if (dn_limit[gi]) begin
                                    dn_q    <= 1'b0;
                                    state_q <= WAIT_UP;
                                end else if (cnt_q == CNT_LAST) begin
                                    dn_q    <= 1'b0;
                                    flt_q   <= 1'b1;
                                    state_q <= FAULT;
                                end else if (rise) begin
                                    dn_q    <= 1'b0;
                                    state_q <= WAIT_UP;
                                end else begin
                                    cnt_q <= cnt_q + TO_W'(1);
                                end
                            end
                            FAULT: begin
                                up_q <= 1'b0;
                                dn_q <= 1'b0;
                                // Leaves even if the limits still conflict;
                                // DECIDE then re-faults on the next cycle.
                                if (clr_fault[gi]) begin
                                    flt_q   <= 1'b0;
                                    state_q <= DECIDE;
                                end
                            end
                            default: begin
                                up_q    <= 1'b0;
                                dn_q    <= 1'b0;
                                flt_q   <= 1'b0;
                                state_q <= DECIDE;
                            end
                        endcase
                    end
                end
            end

            assign motor_up[gi] = up_q;
            assign motor_dn[gi] = dn_q;
            assign fault[gi]    = flt_q;
        end
    endgenerate

endmodule

// File: tb/tb_motor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motor_ctrl: directed vectors for a two-channel motor_ctrl with TIMEOUT=8.
// Outputs are packed as {fault[1:0], motor_dn[1:0], motor_up[1:0]} and
// sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_motor_ctrl;

    localparam int NCH     = 2;
    localparam int TO_W    = 16;
    localparam int TIMEOUT = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] activate;
    logic [NCH-1:0] up_limit;
    logic [NCH-1:0] dn_limit;
    logic [NCH-1:0] clr_fault;
    logic [NCH-1:0] motor_up;
    logic [NCH-1:0] motor_dn;
    logic [NCH-1:0] fault;
    logic [5:0]     outs;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    motor_ctrl #(
        .NCH     (NCH),
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .activate  (activate),
        .up_limit  (up_limit),
        .dn_limit  (dn_limit),
        .clr_fault (clr_fault),
        .motor_up  (motor_up),
        .motor_dn  (motor_dn),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    assign outs = {fault, motor_dn, motor_up};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            miss_cnt++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 'h%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        activate  = '0;
        up_limit  = '0;
        dn_limit  = '0;
        clr_fault = '0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_outs", 32'(outs), 32'h0);
        rst_n = 1'b1;
        step();                                  // edge 1: DECIDE -> WAIT_UP
        chk("decide_outs", 32'(outs), 32'h0);

        // ---------------- up cycle (ch0) ----------------
        activate = 2'b01;
        step();                                  // rise in WAIT_UP
        chk("up_start", 32'(outs), 32'b00_00_01);
        activate = 2'b00;
        step(); step(); step();                  // cnt 1..3
        chk("up_moving", 32'(outs), 32'b00_00_01);
        up_limit = 2'b01;
        step();                                  // limit -> WAIT_DN
        chk("up_stop", 32'(outs), 32'h0);
        step(); step(); step();
        chk("wait_dn_idle", 32'(outs), 32'h0);

        // ---------------- stop / reverse (ch0) ----------------
        activate = 2'b01;
        step();                                  // WAIT_DN -> MOVE_DN
        chk("dn_start", 32'(outs), 32'b00_01_00);
        activate = 2'b00;
        up_limit = 2'b00;
        step(); step();
        activate = 2'b01;
        step();                                  // rise during MOVE_DN: stop
        chk("dn_stop_rise", 32'(outs), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("held_no_motion", 32'(outs), 32'h0);
        end
        activate = 2'b00;
        step();
        activate = 2'b01;
        step();                                  // reversed: MOVE_UP
        chk("reverse_up", 32'(outs), 32'b00_00_01);
        activate = 2'b00;

        // ---------- timeout on ch0 while ch1 runs a full cycle ----------
        activate = 2'b10;
        step();                                  // ch0 on 2 cycles, ch1 up
        chk("ind_ch1_up", 32'(outs), 32'b00_00_11);
        activate = 2'b00;
        up_limit = 2'b10;
        step();
        chk("ind_ch1_uplim", 32'(outs), 32'b00_00_01);
        activate = 2'b10;
        step();
        chk("ind_ch1_dn", 32'(outs), 32'b00_10_01);
        activate = 2'b00;
        up_limit = 2'b00;
        dn_limit = 2'b10;
        step();
        chk("ind_ch1_dnlim", 32'(outs), 32'b00_00_01);
        dn_limit = 2'b00;
        step(); step();
        chk("to_still_on", 32'(outs), 32'b00_00_01);
        step();                                  // 8th motor-on cycle
        chk("to_last_on", 32'(outs), 32'b00_00_01);
        step();                                  // timeout edge
        chk("to_fault", 32'(outs), 32'b01_00_00);

        // activate ignored in FAULT
        activate = 2'b01;
        step();
        activate = 2'b00;
        step();
        activate = 2'b01;
        step();
        chk("fault_ign_act", 32'(outs), 32'b01_00_00);
        activate  = 2'b00;
        clr_fault = 2'b01;
        step();
        chk("clr_fault_drop", 32'(outs), 32'h0);
        clr_fault = 2'b00;
        step();                                  // DECIDE -> WAIT_UP
        chk("post_clr_idle", 32'(outs), 32'h0);
        activate = 2'b01;
        step();
        chk("post_clr_move", 32'(outs), 32'b00_00_01);
        activate = 2'b00;

        // ---------------- limit conflict (ch0 in MOVE_UP) ----------------
        up_limit = 2'b01;
        dn_limit = 2'b01;
        step();
        chk("conflict_fault", 32'(outs), 32'b01_00_00);
        clr_fault = 2'b01;
        step();
        chk("conflict_clr", 32'(outs), 32'h0);
        clr_fault = 2'b00;
        step();
        chk("conflict_refault", 32'(outs), 32'b01_00_00);
        step();
        chk("conflict_stays", 32'(outs), 32'b01_00_00);
        up_limit  = 2'b00;
        dn_limit  = 2'b00;
        clr_fault = 2'b01;
        step();
        clr_fault = 2'b00;
        step();                                  // both in WAIT_UP
        clr_fault = 2'b11;
        step();                                  // no effect outside FAULT
        chk("clr_no_effect", 32'(outs), 32'h0);
        clr_fault = 2'b00;

        // ---------------- simultaneous rises ----------------
        activate = 2'b11;
        step();
        chk("both_up", 32'(outs), 32'b00_00_11);
        activate = 2'b00;
        step();
        up_limit = 2'b11;
        step();
        chk("both_uplim", 32'(outs), 32'h0);
        up_limit = 2'b00;
        activate = 2'b11;
        step();
        activate = 2'b00;
        step();
        chk("both_dn", 32'(outs), 32'b00_11_00);

        // ---------------- async reset mid MOVE_DN ----------------
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'(outs), 32'h0);
        activate = 2'b11;
        step();
        chk("rst_held", 32'(outs), 32'h0);
        rst_n = 1'b1;
        step();                                  // edge 1: DECIDE, rise seen
        chk("rel_edge1", 32'(outs), 32'h0);
        step();                                  // edge 2: motion starts
        chk("rel_edge2", 32'(outs), 32'b00_00_11);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
